// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: data width, default ROB tag width, producer indices, round-robin helper.
`default_nettype none
package cdb_arbiter_pkg;

  localparam int REG_WIDTH     = 32;
  localparam int ROB_WIDTH_DEF = 4;

  localparam int SRC_ALU1 = 0;
  localparam int SRC_ALU2 = 1;
  localparam int SRC_LSB  = 2;

  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO: synchronous write/read, full/empty flags, async reset plus synchronous flush.
`default_nettype none
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  assign rd_data = mem[head];
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (rd_en) head <= head + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[tail] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer FIFOs, round-robin grant, registered value/tag broadcast.
// Define CDB_BYPASS_EN to let an empty producer's live result compete for the bus directly.
`default_nettype none
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_WIDTH  = ROB_WIDTH_DEF
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           clear_signal,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*REG_WIDTH-1:0]   src_value,
  input  logic [NUM_SRC*ROB_WIDTH-1:0]   src_tag,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic                           cdb_valid,
  output logic [REG_WIDTH-1:0]           cdb_value,
  output logic [ROB_WIDTH-1:0]           cdb_tag,
  output logic [$clog2(NUM_SRC)-1:0]     cdb_src,
  output logic                           idle
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int ENT_W = REG_WIDTH + ROB_WIDTH;

  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] req;
  logic [ENT_W-1:0]   head_data [NUM_SRC];
  logic [ENT_W-1:0]   live_data [NUM_SRC];

  logic [SRC_W-1:0]   rr_ptr;
  logic               found;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   winner_next;
  logic [ENT_W-1:0]   win_data;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign live_data[i] = {src_value[i*REG_WIDTH +: REG_WIDTH], src_tag[i*ROB_WIDTH +: ROB_WIDTH]};
    assign src_ready[i] = rdy_in & ~fifo_full[i];
`ifdef CDB_BYPASS_EN
    assign req[i]  = ~fifo_empty[i] | (src_valid[i] & src_ready[i]);
    // A bypass winner goes straight to the bus, so it must not also be enqueued.
    assign push[i] = src_valid[i] & src_ready[i] & ~clear_signal
                   & ~(found & (winner == SRC_W'(i)) & fifo_empty[i]);
`else
    assign req[i]  = ~fifo_empty[i];
    assign push[i] = src_valid[i] & src_ready[i] & ~clear_signal;
`endif
    assign pop[i] = rdy_in & ~clear_signal & found & (winner == SRC_W'(i)) & ~fifo_empty[i];

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .flush   (rdy_in & clear_signal),
      .wr_en   (push[i]),
      .wr_data (live_data[i]),
      .rd_en   (pop[i]),
      .rd_data (head_data[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      automatic int idx = rr_index(int'(rr_ptr), k, NUM_SRC);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = SRC_W'(idx);
`ifdef CDB_BYPASS_EN
        win_data = fifo_empty[idx] ? live_data[idx] : head_data[idx];
`else
        win_data = head_data[idx];
`endif
      end
    end
  end

  assign winner_next = SRC_W'(rr_index(int'(winner), 1, NUM_SRC));
  assign idle        = ~cdb_valid & (&fifo_empty);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid <= 1'b0;
      cdb_value <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (rdy_in) begin
      if (clear_signal) begin
        cdb_valid <= 1'b0;
        rr_ptr    <= '0;
      end else if (found) begin
        cdb_valid              <= 1'b1;
        {cdb_value, cdb_tag}   <= win_data;
        cdb_src                <= winner;
        rr_ptr                 <= winner_next;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
